// File: rtl/radix4_booth_seq_mult.sv
// Sequential radix-4 Booth multiplier: IDLE/BUSY/DONE control FSM with valid/ready on both sides.
// Each BUSY cycle adds STEPS_PER_CYCLE Booth-recoded partial products into a wide accumulator.
module radix4_booth_seq_mult #(
    parameter int WIDTH           = 8,
    parameter int STEPS_PER_CYCLE = 1,
    parameter int TAG_WIDTH       = 1,
    parameter bit CHECK_PARAM     = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_signed,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    input  logic [TAG_WIDTH-1:0]   in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*WIDTH-1:0]     out_product,
    output logic [TAG_WIDTH-1:0]   out_tag,
    output logic                   busy
);

    localparam int NDIG  = WIDTH / 2 + 1;
    localparam int EW    = WIDTH + 2;
    localparam int ACC_W = 2 * WIDTH + 4;
    localparam int CW    = $clog2(2 * NDIG + 1) + 1;

    if (CHECK_PARAM) begin : g_param_check
        if ((WIDTH < 2) || (WIDTH % 2 != 0) || (STEPS_PER_CYCLE < 1) || (STEPS_PER_CYCLE > NDIG)) begin : g_bad
            $fatal(1, "radix4_booth_seq_mult: illegal WIDTH or STEPS_PER_CYCLE");
        end
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q;
    logic [EW-1:0]          a_q;
    logic [EW-1:0]          b_q;
    logic [ACC_W-1:0]       acc_q;
    logic [ACC_W-1:0]       acc_d;
    logic [CW-1:0]          cnt_q;
    logic [TAG_WIDTH-1:0]   tag_q;

    logic                   accept;
    logic                   last_step;
    logic [EW:0]            b_pad;
    logic [ACC_W-1:0]       a_ext;
    logic [CW-1:0]          idx;
    logic [2:0]             trip;
    logic [ACC_W-1:0]       pp;

    // Handshake: a transfer happens on any cycle where valid and ready are both high at the
    // rising edge; ready never waits on valid, and flush forces in_ready low for its cycle.
    assign in_ready  = !flush && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign last_step = (cnt_q + CW'(STEPS_PER_CYCLE)) >= CW'(NDIG);

    assign out_valid   = (state_q == DONE);
    assign busy        = (state_q == BUSY);
    assign out_product = acc_q[2*WIDTH-1:0];
    assign out_tag     = tag_q;

    // b_pad carries the implicit b[-1]=0 so digit i reads b_pad[2i+2:2i].
    assign b_pad = {b_q, 1'b0};
    assign a_ext = {{(ACC_W - EW){a_q[EW-1]}}, a_q};

    always_comb begin
        acc_d = acc_q;
        idx   = '0;
        trip  = '0;
        pp    = '0;
        for (int s = 0; s < STEPS_PER_CYCLE; s++) begin
            idx  = cnt_q + CW'(s);
            trip = 3'(b_pad >> {idx, 1'b0});
            case (trip)
                3'b001, 3'b010: pp = a_ext;
                3'b011:         pp = a_ext << 1;
                3'b100:         pp = -(a_ext << 1);
                3'b101, 3'b110: pp = -a_ext;
                default:        pp = '0;
            endcase
            if (idx < CW'(NDIG)) begin
                acc_d = acc_d + (pp << {idx, 1'b0});
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            tag_q   <= '0;
        end else if (flush) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                BUSY: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CW'(STEPS_PER_CYCLE);
                    if (last_step) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            // Accept overrides the IDLE/DONE transitions above; operands are only sampled here.
            if (accept) begin
                a_q     <= in_signed ? {{2{in_a[WIDTH-1]}}, in_a} : {2'b00, in_a};
                b_q     <= in_signed ? {{2{in_b[WIDTH-1]}}, in_b} : {2'b00, in_b};
                tag_q   <= in_tag;
                acc_q   <= '0;
                cnt_q   <= '0;
                state_q <= BUSY;
            end
        end
    end

endmodule
